delta_decoder: RTL

- Reconstructs absolute samples from a stream of two's-complement differences: value[n] = value[n-1] + delta[n], mod 2^WIDTH.
- Inverse of the difference/subtraction path: the encoder emits a - b, and this block adds the difference back to the running value.
- Sits between a delta-coded input stream and any consumer of absolute values.
- Valid/ready handshake on both sides, with a one-deep registered output stage.

---
 rtl/delta_decoder.sv | 54 +++++
 1 files changed

// File: rtl/delta_decoder.sv
// Delta decoder: rebuilds absolute samples from two's-complement differences
// (value[n] = value[n-1] + delta[n] mod 2^WIDTH) behind a one-deep registered output.
module delta_decoder #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_delta,
    input  logic                 in_first,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_value,
    output logic                 out_wrap,
    output logic [CNT_WIDTH-1:0] sample_count
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign sum      = {1'b0, acc} + {1'b0, in_delta};

    // The accumulator and the output sample always load the same value,
    // so one register serves as both.
    assign out_value = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            out_valid    <= 1'b0;
            out_wrap     <= 1'b0;
            sample_count <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            if (in_first) begin
                acc          <= in_delta;
                out_wrap     <= 1'b0;
                sample_count <= CNT_WIDTH'(1);
            end else begin
                acc          <= sum[WIDTH-1:0];
                out_wrap     <= sum[WIDTH];
                sample_count <= sample_count + 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
